// File: rtl/tlb_cmd_unit_pkg.sv
// Shared types for the TLB command unit: command opcodes, TLB entry layout,
// response bundle, ELO bit offsets and INVTLB predicate decoding.
package tlb_cmd_unit_pkg;

    typedef enum logic [2:0] {
        TLB_SRCH = 3'd0,
        TLB_RD   = 3'd1,
        TLB_WR   = 3'd2,
        TLB_FILL = 3'd3,
        TLB_INV  = 3'd4
    } TlbOp;

    localparam logic [2:0] CLEAR_ALL0              = 3'd0;
    localparam logic [2:0] CLEAR_ALL1              = 3'd1;
    localparam logic [2:0] CLEAR_G1                = 3'd2;
    localparam logic [2:0] CLEAR_G0                = 3'd3;
    localparam logic [2:0] CLEAR_G0_ASID           = 3'd4;
    localparam logic [2:0] CLEAR_G0_ASID_VA        = 3'd5;
    localparam logic [2:0] CLEAR_G1_OR_ASID_AND_VA = 3'd6;

    // Bit offsets of the fields inside TLBELO0/TLBELO1
    localparam int ELO_V      = 0;
    localparam int ELO_D      = 1;
    localparam int ELO_PLV_LO = 2;
    localparam int ELO_MAT_LO = 4;
    localparam int ELO_G      = 6;
    localparam int ELO_PPN_LO = 8;

    // Page size code for which only VPPN[18:9] takes part in the compare
    localparam logic [5:0] PS_4M = 6'd21;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } PhytranItem;

    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [18:0] vppn;
    } CompareItem;

    typedef struct packed {
        CompareItem cmp;
        PhytranItem p0;
        PhytranItem p1;
    } TlbItem;

    typedef struct packed {
        logic        ne;
        logic [7:0]  idx;
        logic [5:0]  ps;
        logic [31:0] ehi;
        logic [31:0] elo0;
        logic [31:0] elo1;
        logic [9:0]  asid;
    } TlbRsp;

    // Global-bit qualifier applied by the per-entry comparator
    typedef enum logic [2:0] {
        GSEL_ANY         = 3'd0,
        GSEL_G1          = 3'd1,
        GSEL_G0          = 3'd2,
        GSEL_G0_ASID     = 3'd3,
        GSEL_G1_OR_ASID  = 3'd4,
        GSEL_NONE        = 3'd5
    } GSel;

    // Rebuild the CSR image of one physical half of an entry
    function automatic logic [31:0] phy_to_elo(input PhytranItem p, input logic g);
        logic [31:0] w_elo;
        w_elo                           = 32'h0000_0000;
        w_elo[ELO_V]                    = p.v;
        w_elo[ELO_D]                    = p.d;
        w_elo[ELO_PLV_LO +: 2]          = p.plv;
        w_elo[ELO_MAT_LO +: 2]          = p.mat;
        w_elo[ELO_G]                    = g;
        w_elo[ELO_PPN_LO +: 20]         = p.ppn;
        return w_elo;
    endfunction

    // Global-bit qualifier for each INVTLB op
    function automatic GSel inv_gsel(input logic [2:0] op);
        GSel w_sel;
        case (op)
            CLEAR_ALL0, CLEAR_ALL1:      w_sel = GSEL_ANY;
            CLEAR_G1:                    w_sel = GSEL_G1;
            CLEAR_G0:                    w_sel = GSEL_G0;
            CLEAR_G0_ASID,
            CLEAR_G0_ASID_VA:            w_sel = GSEL_G0_ASID;
            CLEAR_G1_OR_ASID_AND_VA:     w_sel = GSEL_G1_OR_ASID;
            default:                     w_sel = GSEL_NONE;
        endcase
        return w_sel;
    endfunction

    // INVTLB ops that additionally require a VA match
    function automatic logic inv_chk_va(input logic [2:0] op);
        logic w_chk;
        case (op)
            CLEAR_G0_ASID_VA,
            CLEAR_G1_OR_ASID_AND_VA:     w_chk = 1'b1;
            default:                     w_chk = 1'b0;
        endcase
        return w_chk;
    endfunction

endpackage

// File: rtl/tlb_cmd_unit_entry_match.sv
// Combinational compare of one TLB entry against an ASID/VPPN key with a
// selectable global-bit qualifier; VA compare honours the entry's page size.
module tlb_entry_match
    import tlb_cmd_unit_pkg::*;
(
    input  CompareItem  i_cmp,
    input  logic [9:0]  i_asid,
    input  logic [18:0] i_vppn,
    input  GSel         i_gsel,
    input  logic        i_chk_va,
    output logic        o_hit
);

    logic w_asid_eq;
    logic w_va_eq;
    logic w_g_ok;

    // Evaluate ASID/VA equality and the global-bit qualifier for this entry
    always_comb begin
        w_asid_eq = (i_cmp.asid == i_asid);
        if (i_cmp.ps == PS_4M) begin
            w_va_eq = (i_cmp.vppn[18:9] == i_vppn[18:9]);
        end else begin
            w_va_eq = (i_cmp.vppn == i_vppn);
        end
        case (i_gsel)
            GSEL_ANY:        w_g_ok = 1'b1;
            GSEL_G1:         w_g_ok = i_cmp.g;
            GSEL_G0:         w_g_ok = ~i_cmp.g;
            GSEL_G0_ASID:    w_g_ok = ~i_cmp.g & w_asid_eq;
            GSEL_G1_OR_ASID: w_g_ok = i_cmp.g | w_asid_eq;
            default:         w_g_ok = 1'b0;
        endcase
        o_hit = i_cmp.e & w_g_ok & (~i_chk_va | w_va_eq);
    end

endmodule

// File: rtl/tlb_cmd_unit.sv
// TLB command responder: owns the entry array and executes SRCH/RD/WR/FILL
// in a single EXEC cycle and INVTLB as a one-entry-per-cycle sweep.
module tlb_cmd_unit
    import tlb_cmd_unit_pkg::*;
#(
    parameter int TLBNUM     = 16,
    parameter int TLBNUMSIZE = $clog2(TLBNUM)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [2:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_va,
    input  logic [31:0]           csr_tlbidx,
    input  logic [31:0]           csr_tlbehi,
    input  logic [31:0]           csr_tlbelo0,
    input  logic [31:0]           csr_tlbelo1,
    input  logic [9:0]            csr_asid,
    output logic                  rsp_valid,
    output logic                  rsp_ne,
    output logic [TLBNUMSIZE-1:0] rsp_idx,
    output logic [5:0]            rsp_ps,
    output logic [31:0]           rsp_ehi,
    output logic [31:0]           rsp_elo0,
    output logic [31:0]           rsp_elo1,
    output logic [9:0]            rsp_asid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

    state_e                r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    TlbRsp                 r_rsp;
    TlbOp                  r_op;
    logic [TLBNUMSIZE-1:0] r_idx;
    logic                  r_e_n;
    logic [5:0]            r_ps;
    logic [18:0]           r_vppn;
    logic [31:0]           r_elo0;
    logic [31:0]           r_elo1;
    logic [9:0]            r_asid;
    logic [2:0]            r_inv_op;
    logic [9:0]            r_inv_asid;
    logic [18:0]           r_inv_va;
    logic [TLBNUMSIZE-1:0] r_sweep_idx;
    logic [TLBNUMSIZE-1:0] r_fill_cnt;
    TlbItem                r_tlb [TLBNUM];

    logic [TLBNUM-1:0]     w_srch_hit;
    logic                  w_srch_found;
    logic [TLBNUMSIZE-1:0] w_srch_idx;
    logic                  w_sweep_hit;
    logic                  w_sweep_last;
    logic                  w_accept;
    TlbItem                w_rd_item;
    TlbItem                w_new_item;
    TlbRsp                 w_exec_rsp;

    assign w_accept     = cmd_valid & r_cmd_ready & (r_state == ST_IDLE);
    assign w_sweep_last = (r_sweep_idx == TLBNUMSIZE'(TLBNUM - 1));
    assign w_rd_item    = r_tlb[r_idx];

    // CSR bits that carry no meaning for this unit
    logic w_unused_bits;
    assign w_unused_bits = ^{csr_tlbidx[30], csr_tlbidx[23:TLBNUMSIZE], csr_tlbehi[12:0],
                             r_elo0[31:28], r_elo0[7], r_elo1[31:28], r_elo1[7], r_rsp.idx};

    // Per-entry search comparators, all sharing the latched key
    for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_srch
        tlb_entry_match u_srch_match (
            .i_cmp    (r_tlb[gi].cmp),
            .i_asid   (r_asid),
            .i_vppn   (r_vppn),
            .i_gsel   (GSEL_G1_OR_ASID),
            .i_chk_va (1'b1),
            .o_hit    (w_srch_hit[gi])
        );
    end

    // Single comparator walked over the array during an INVTLB sweep
    tlb_entry_match u_sweep_match (
        .i_cmp    (r_tlb[r_sweep_idx].cmp),
        .i_asid   (r_inv_asid),
        .i_vppn   (r_inv_va),
        .i_gsel   (inv_gsel(r_inv_op)),
        .i_chk_va (inv_chk_va(r_inv_op)),
        .o_hit    (w_sweep_hit)
    );

    // Lowest-index priority encode of the search hits
    always_comb begin
        w_srch_found = 1'b0;
        w_srch_idx   = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (w_srch_hit[i]) begin
                w_srch_found = 1'b1;
                w_srch_idx   = TLBNUMSIZE'(i);
            end else begin
                w_srch_found = w_srch_found;
            end
        end
    end

    // Assemble the entry image written by WR/FILL from the latched CSRs
    always_comb begin
        w_new_item          = '0;
        w_new_item.cmp.e    = ~r_e_n;
        w_new_item.cmp.asid = r_asid;
        w_new_item.cmp.g    = r_elo0[ELO_G] & r_elo1[ELO_G];
        w_new_item.cmp.ps   = r_ps;
        w_new_item.cmp.vppn = r_vppn;
        w_new_item.p0.v     = r_elo0[ELO_V];
        w_new_item.p0.d     = r_elo0[ELO_D];
        w_new_item.p0.plv   = r_elo0[ELO_PLV_LO +: 2];
        w_new_item.p0.mat   = r_elo0[ELO_MAT_LO +: 2];
        w_new_item.p0.ppn   = r_elo0[ELO_PPN_LO +: 20];
        w_new_item.p1.v     = r_elo1[ELO_V];
        w_new_item.p1.d     = r_elo1[ELO_D];
        w_new_item.p1.plv   = r_elo1[ELO_PLV_LO +: 2];
        w_new_item.p1.mat   = r_elo1[ELO_MAT_LO +: 2];
        w_new_item.p1.ppn   = r_elo1[ELO_PPN_LO +: 20];
    end

    // Response payload for the single-cycle ops
    always_comb begin
        w_exec_rsp = '0;
        case (r_op)
            TLB_SRCH: begin
                w_exec_rsp.ne  = ~w_srch_found;
                w_exec_rsp.idx = 8'(w_srch_idx);
            end
            TLB_RD: begin
                if (w_rd_item.cmp.e) begin
                    w_exec_rsp.ne   = 1'b0;
                    w_exec_rsp.ps   = w_rd_item.cmp.ps;
                    w_exec_rsp.ehi  = {w_rd_item.cmp.vppn, 13'h0000};
                    w_exec_rsp.elo0 = phy_to_elo(w_rd_item.p0, w_rd_item.cmp.g);
                    w_exec_rsp.elo1 = phy_to_elo(w_rd_item.p1, w_rd_item.cmp.g);
                    w_exec_rsp.asid = w_rd_item.cmp.asid;
                end else begin
                    w_exec_rsp.ne = 1'b1;
                end
            end
            default: begin
                w_exec_rsp.ne = 1'b0;
            end
        endcase
    end

    // Free-running replacement pointer used by FILL
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_fill_cnt <= '0;
        end else begin
            r_fill_cnt <= r_fill_cnt + TLBNUMSIZE'(1);
        end
    end

    // Entry array: WR/FILL writes in EXEC, sweep clears E of matching entries
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                r_tlb[i] <= '0;
            end
        end else if (r_state == ST_EXEC && (r_op == TLB_WR || r_op == TLB_FILL)) begin
            r_tlb[r_idx] <= w_new_item;
        end else if (r_state == ST_SWEEP && w_sweep_hit) begin
            r_tlb[r_sweep_idx].cmp.e <= 1'b0;
        end
    end

    // Control FSM: accept/latch command, run EXEC or SWEEP, register response
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_op        <= TLB_SRCH;
            r_idx       <= '0;
            r_e_n       <= 1'b0;
            r_ps        <= 6'd0;
            r_vppn      <= 19'd0;
            r_elo0      <= 32'h0000_0000;
            r_elo1      <= 32'h0000_0000;
            r_asid      <= 10'd0;
            r_inv_op    <= 3'd0;
            r_inv_asid  <= 10'd0;
            r_inv_va    <= 19'd0;
            r_sweep_idx <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= TlbOp'(cmd_op);
                        r_idx       <= (TlbOp'(cmd_op) == TLB_FILL) ? r_fill_cnt
                                                                    : csr_tlbidx[TLBNUMSIZE-1:0];
                        r_e_n       <= csr_tlbidx[31];
                        r_ps        <= csr_tlbidx[29:24];
                        r_vppn      <= csr_tlbehi[31:13];
                        r_elo0      <= csr_tlbelo0;
                        r_elo1      <= csr_tlbelo1;
                        r_asid      <= csr_asid;
                        r_inv_op    <= inv_op;
                        r_inv_asid  <= inv_asid;
                        r_inv_va    <= inv_va;
                        r_sweep_idx <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= (TlbOp'(cmd_op) == TLB_INV) ? ST_SWEEP : ST_EXEC;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_rsp       <= w_exec_rsp;
                    r_rsp_valid <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_SWEEP: begin
                    if (w_sweep_last) begin
                        r_rsp       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + TLBNUMSIZE'(1);
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_ne    = r_rsp.ne;
    assign rsp_idx   = r_rsp.idx[TLBNUMSIZE-1:0];
    assign rsp_ps    = r_rsp.ps;
    assign rsp_ehi   = r_rsp.ehi;
    assign rsp_elo0  = r_rsp.elo0;
    assign rsp_elo1  = r_rsp.elo1;
    assign rsp_asid  = r_rsp.asid;

endmodule

// File: tb/tb_tlb_cmd_unit.sv
// Directed bench for tlb_cmd_unit with hand-computed expected values.
module tb_tlb_cmd_unit;
    import tlb_cmd_unit_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_va;
    logic [31:0] csr_tlbidx;
    logic [31:0] csr_tlbehi;
    logic [31:0] csr_tlbelo0;
    logic [31:0] csr_tlbelo1;
    logic [9:0]  csr_asid;
    logic        rsp_valid;
    logic        rsp_ne;
    logic [3:0]  rsp_idx;
    logic [5:0]  rsp_ps;
    logic [31:0] rsp_ehi;
    logic [31:0] rsp_elo0;
    logic [31:0] rsp_elo1;
    logic [9:0]  rsp_asid;

    int n_checks;
    int n_fail;

    tlb_cmd_unit #(.TLBNUM(16)) u_dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .inv_op      (inv_op),
        .inv_asid    (inv_asid),
        .inv_va      (inv_va),
        .csr_tlbidx  (csr_tlbidx),
        .csr_tlbehi  (csr_tlbehi),
        .csr_tlbelo0 (csr_tlbelo0),
        .csr_tlbelo1 (csr_tlbelo1),
        .csr_asid    (csr_asid),
        .rsp_valid   (rsp_valid),
        .rsp_ne      (rsp_ne),
        .rsp_idx     (rsp_idx),
        .rsp_ps      (rsp_ps),
        .rsp_ehi     (rsp_ehi),
        .rsp_elo0    (rsp_elo0),
        .rsp_elo1    (rsp_elo1),
        .rsp_asid    (rsp_asid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for its response and check latency/busy behaviour
    task automatic issue(input logic [2:0] op, input int exp_lat, input string tag);
        int  lat;
        int  rdy;
        bit  got;
        bit  acc;
        @(negedge aclk);
        check({tag, "_rv_low"}, {63'd0, rsp_valid}, 64'd0);
        cmd_op    = op;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            if (cmd_ready) acc = 1'b1;
            else @(negedge aclk);
        end
        check({tag, "_accept"}, {63'd0, acc}, 64'd1);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        rdy = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge aclk);
            lat++;
            if (rsp_valid) got = 1'b1;
            else if (cmd_ready) rdy++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(rdy), 64'd0);
    endtask

    task automatic do_wr(input logic [31:0] idx, input logic [31:0] ehi,
                         input logic [31:0] e0, input logic [31:0] e1, input string tag);
        csr_tlbidx  = idx;
        csr_tlbehi  = ehi;
        csr_tlbelo0 = e0;
        csr_tlbelo1 = e1;
        issue(TLB_WR, 2, tag);
        check({tag, "_ne"}, {63'd0, rsp_ne}, 64'd0);
    endtask

    task automatic do_rd_ne(input logic [31:0] idx, input logic exp_ne, input string tag);
        csr_tlbidx = idx;
        issue(TLB_RD, 2, tag);
        check({tag, "_ne"}, {63'd0, rsp_ne}, {63'd0, exp_ne});
    endtask

    task automatic do_srch(input logic [31:0] ehi, input logic [9:0] asid,
                           input logic exp_ne, input logic [3:0] exp_idx, input string tag);
        csr_tlbehi = ehi;
        csr_asid   = asid;
        issue(TLB_SRCH, 2, tag);
        check({tag, "_ne"}, {63'd0, rsp_ne}, {63'd0, exp_ne});
        check({tag, "_idx"}, {60'd0, rsp_idx}, {60'd0, exp_idx});
    endtask

    initial begin
        int lat;
        int viol;
        bit got;
        n_checks    = 0;
        n_fail      = 0;
        aresetn     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        inv_op      = 3'd0;
        inv_asid    = 10'd0;
        inv_va      = 19'd0;
        csr_tlbidx  = 32'd0;
        csr_tlbehi  = 32'd0;
        csr_tlbelo0 = 32'd0;
        csr_tlbelo1 = 32'd0;
        csr_asid    = 10'd0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_rv", {63'd0, rsp_valid}, 64'd0);
        check("rst_ehi", {32'd0, rsp_ehi}, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rel_ready", {63'd0, cmd_ready}, 64'd1);

        // RD of an empty entry
        csr_tlbidx = 32'd3;
        issue(TLB_RD, 2, "rd3");
        check("rd3_ne", {63'd0, rsp_ne}, 64'd1);
        check("rd3_ehi", {32'd0, rsp_ehi}, 64'd0);
        check("rd3_elo0", {32'd0, rsp_elo0}, 64'd0);
        check("rd3_elo1", {32'd0, rsp_elo1}, 64'd0);
        check("rd3_ps", {58'd0, rsp_ps}, 64'd0);
        check("rd3_asid", {54'd0, rsp_asid}, 64'd0);

        // WR idx 5 (VPPN 0x12345, PS 12, ASID 0x2A, G 0) then read back
        csr_asid = 10'h2A;
        do_wr(32'h0C00_0005, 32'h2468_A000, 32'h0ABC_D05F, 32'h0001_230E, "wr5");
        do_rd_ne(32'd5, 1'b0, "rd5");
        check("rd5_ehi", {32'd0, rsp_ehi}, 64'h2468_A000);
        check("rd5_elo0", {32'd0, rsp_elo0}, 64'h0ABC_D01F);
        check("rd5_elo1", {32'd0, rsp_elo1}, 64'h0001_230E);
        check("rd5_ps", {58'd0, rsp_ps}, 64'd12);
        check("rd5_asid", {54'd0, rsp_asid}, 64'h2A);

        // Two entries with same VPPN 0x0ABCD/ASID: lowest index wins
        do_wr(32'h0C00_0002, 32'h1579_A000, 32'h0000_1001, 32'h0000_2001, "wr2");
        do_wr(32'h0C00_0009, 32'h1579_A000, 32'h0000_3001, 32'h0000_4001, "wr9");
        do_srch(32'h1579_A000, 10'h2A, 1'b0, 4'd2, "s_lo");
        do_srch(32'h1579_A000, 10'h2B, 1'b1, 4'd0, "s_asid");

        // Global entry idx 12 hits under any ASID
        csr_asid = 10'h2A;
        do_wr(32'h0C00_000C, 32'h2222_2000, 32'h0005_5543, 32'h0005_5543, "wr12");
        do_srch(32'h2222_2000, 10'h2B, 1'b0, 4'd12, "s_g");

        // 4M page at idx 7: only VPPN[18:9] compared
        csr_asid = 10'h2A;
        do_wr(32'h1500_0007, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, "wr7");
        do_srch(32'h803F_E000, 10'h2A, 1'b0, 4'd7, "s_4m_hit");
        do_srch(32'h8040_0000, 10'h2A, 1'b1, 4'd0, "s_4m_miss");

        // INVTLB op 5 targets entry 5; a RD held on cmd_valid waits for IDLE
        inv_op   = CLEAR_G0_ASID_VA;
        inv_asid = 10'h2A;
        inv_va   = 19'h12345;
        @(negedge aclk);
        cmd_op    = TLB_INV;
        cmd_valid = 1'b1;
        @(posedge aclk);
        #1;
        cmd_op     = TLB_RD;
        csr_tlbidx = 32'd5;
        lat  = 0;
        viol = 0;
        got  = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge aclk);
            lat++;
            if (rsp_valid) got = 1'b1;
            else if (cmd_ready) viol++;
        end
        check("inv5_lat", 64'(lat), 64'd17);
        check("inv5_busy", 64'(viol), 64'd0);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge aclk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        check("held_rd_lat", 64'(lat), 64'd2);
        check("held_rd5_ne", {63'd0, rsp_ne}, 64'd1);
        do_rd_ne(32'd2, 1'b0, "inv_rd2");
        do_rd_ne(32'd7, 1'b0, "inv_rd7");
        do_rd_ne(32'd12, 1'b0, "inv_rd12");

        // INVTLB op 2 removes only global entries
        inv_op = CLEAR_G1;
        issue(TLB_INV, 17, "inv2");
        do_srch(32'h2222_2000, 10'h2B, 1'b1, 4'd0, "inv2_s_g");
        do_srch(32'h1579_A000, 10'h2A, 1'b0, 4'd2, "inv2_s_2");

        // Reset while the sweep is at index 7
        inv_op = CLEAR_ALL0;
        @(negedge aclk);
        cmd_op    = TLB_INV;
        cmd_valid = 1'b1;
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        repeat (7) @(posedge aclk);
        #1 aresetn = 1'b0;
        viol = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            if (rsp_valid) viol++;
        end
        check("rst_sweep_rv", 64'(viol), 64'd0);
        check("rst_sweep_ready", {63'd0, cmd_ready}, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_sweep_rel_ready", {63'd0, cmd_ready}, 64'd1);
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            if (rsp_valid) viol++;
        end
        check("rst_sweep_no_rsp", 64'(viol), 64'd0);
        do_rd_ne(32'd9, 1'b1, "rst_rd9");
        do_rd_ne(32'd2, 1'b1, "rst_rd2");

        // FILL lands somewhere; a search must then find it
        csr_tlbidx  = 32'h0C00_0000;
        csr_tlbehi  = 32'h0EEE_E000;
        csr_tlbelo0 = 32'h0000_0001;
        csr_tlbelo1 = 32'h0000_0001;
        csr_asid    = 10'h15;
        issue(TLB_FILL, 2, "fill");
        check("fill_ne", {63'd0, rsp_ne}, 64'd0);
        csr_tlbehi = 32'h0EEE_E000;
        csr_asid   = 10'h15;
        issue(TLB_SRCH, 2, "fill_s");
        check("fill_s_ne", {63'd0, rsp_ne}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_cmd_unit.md
Name: tlb_cmd_unit

Overview:
- TLB-side responder for the TlbCtrl/TlbData commands that the WB stage issues for TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Owns the TLBNUM-entry TlbItem array.
- Executes one command at a time under a valid/ready handshake.
- Returns a single-cycle response carrying the values the CSR file loads into TLBIDX/TLBEHI/TLBELO0/TLBELO1/ASID.
- INVTLB runs as a multi-cycle sweep, one entry per cycle.

Parameters:
- TLBNUM, 16, number of entries; must be a power of 2.
- TLBNUMSIZE, $clog2(TLBNUM), width of the entry index.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous reset, active low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit idle; a command is accepted when cmd_valid&cmd_ready at a rising edge.
- cmd_op  in  3  TlbOp: SRCH, RD, WR, FILL, INV.
- inv_op  in  3  INVTLB op code (CLEAR_ALL0..CLEAR_G1_OR_ASID_AND_VA).
- inv_asid  in  10  ASID operand for INVTLB.
- inv_va  in  19  VA[31:13] operand for INVTLB.
- csr_tlbidx  in  32  TLBIDX CSR value.
- csr_tlbehi  in  32  TLBEHI CSR value.
- csr_tlbelo0  in  32  TLBELO0 CSR value.
- csr_tlbelo1  in  32  TLBELO1 CSR value.
- csr_asid  in  10  ASID.ASID field.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_ne  out  1  SRCH: miss; RD: entry invalid.
- rsp_idx  out  TLBNUMSIZE  SRCH hit index.
- rsp_ps  out  6  RD page size.
- rsp_ehi  out  32  RD: {VPPN,13'b0}.
- rsp_elo0  out  32  RD: TLBELO0 image.
- rsp_elo1  out  32  RD: TLBELO1 image.
- rsp_asid  out  10  RD ASID.

Behaviour:
- Reset (aresetn=0 at an edge):
  - All entry E=0 and all other entry fields 0.
  - State IDLE, fill counter 0.
  - All rsp_* outputs 0, cmd_ready=0 during reset and 1 from the first cycle after release.
  - Reset mid-sweep aborts the sweep; no rsp_valid is produced.
- States: IDLE, EXEC, SWEEP. cmd_ready=1 only in IDLE.
- Accept: the inputs are latched at the accept edge and the CSR inputs are ignored afterwards.
  - Every op except INV moves to EXEC.
  - INV moves to SWEEP with sweep index 0.
- EXEC (exactly one cycle), then back to IDLE; rsp_valid pulses on the edge leaving EXEC (latency 2 from accept).
  - SRCH: hit(i) = E & (G | ASID==latched asid) & VPPN match.
    - VPPN match compares VPPN[18:9] if PS==21, otherwise all 19 bits.
    - The search key is TLBEHI[31:13].
    - Multiple hits resolve to the lowest index.
    - Hit: rsp_ne=0, rsp_idx=index. Miss: rsp_ne=1, rsp_idx=0.
  - RD: index = tlbidx[TLBNUMSIZE-1:0].
    - E=1: rsp_ne=0 and the fields are packed into CSR layout (ELO: V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8]).
    - E=0: rsp_ne=1 and all other rsp_* are 0.
  - WR: entry[tlbidx idx] is written with:
    - E = ~tlbidx[31], PS = tlbidx[29:24], VPPN = tlbehi[31:13];
    - ASID = csr_asid, G = elo0[6] & elo1[6];
    - PI0 from elo0, PI1 from elo1.
    - The response has rsp_ne=0 and no other data.
  - FILL: same as WR, but the index is the fill counter value at the accept edge.
- Fill counter:
  - Free-running, increments every cycle and wraps modulo TLBNUM.
  - It is pseudo-random replacement; software must not depend on its value.
- SWEEP:
  - One entry per cycle, index 0..TLBNUM-1; a matching entry has E cleared at that edge.
  - The last index returns to IDLE with rsp_valid set (latency TLBNUM+1 from accept).
  - Match predicates by inv_op:
    - 0/1: all entries.
    - 2: G=1.
    - 3: G=0.
    - 4: G=0 & ASID==inv_asid.
    - 5: G=0 & ASID==inv_asid & VA match.
    - 6: (G=1 | ASID==inv_asid) & VA match.
    - 7: no entry matches; the op completes normally. INE is raised by the decoder, not here.
  - VA match uses the entry's own PS rule, as in SRCH.
- rsp_* hold their value until the next response; rsp_valid has no backpressure.
- cmd_valid while busy: the command is not accepted and the initiator holds it.

Decomposition:
- Add to cpuDefine:
  - TlbOp enum (SRCH, RD, WR, FILL, INV).
  - TlbRsp struct (ne, idx, ps, ehi, elo0, elo1, asid).
  - ELO field-offset localparams.
- Reuse the existing TlbItem, CompareItem, PhytranItem and CLEAR_* from cpuDefine.
- Sub-module tlb_entry_match: combinational per-entry compare (asid, vppn, G-mode select) returning hit. It is instantiated TLBNUM times for SRCH and once for the sweep.

Test Plan:
- Reset, then RD idx 3 -> rsp_ne=1, all other rsp_* 0, rsp_valid exactly 2 cycles after accept.
- WR idx 5 with VPPN=0x12345, PS=12, ASID=0x2A, G=0, elo0=0x0ABCD05F, followed by RD idx 5 -> fields round-trip: rsp_ehi=0x2468A000, rsp_elo0=0x0ABCD01F (G bit 0 because elo1[6]=0).
- WR idx 2 and idx 9 with the same VPPN/ASID, then SRCH -> rsp_idx=2, rsp_ne=0. Changing csr_asid to 0x2B gives rsp_ne=1; the same search with G=1 entries hits.
- PS=21 entry VPPN=0x40000, SRCH key 0x401FF -> hit; key 0x40200 -> miss.
- INV op 5 with asid 0x2A, va matching entry 5 only -> entry 5 E=0 and others intact, rsp_valid at accept+17, cmd_ready=0 throughout. Asserting cmd_valid mid-sweep -> not accepted until IDLE.
- Reset asserted at sweep index 7 -> no rsp_valid, all entries invalid, cmd_ready=1 in the first cycle after release.
